// File: rtl/rtc_bus_ctrl_pkg.sv
// Shared definitions for the RTC multiplexed-bus controller: FSM encoding,
// counter width and the default bus phase length.
package rtc_bus_ctrl_pkg;

    localparam int CNT_W         = 8;
    localparam int PHASE_CYC_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_HOLD,
        ST_ACCESS,
        ST_RECOVER
    } state_e;

endpackage

// File: rtl/rtc_phase_timer.sv
// Loadable down-counter that saturates at zero; expired_o flags the final
// cycle of the current phase.
module rtc_phase_timer
    import rtc_bus_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             expired_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/rtc_bus_ctrl.sv
// Sequencer for a multiplexed-AD RTC bus: address phase, address hold,
// data access and recovery, each PHASE_CYC clocks long.
module rtc_bus_ctrl
    import rtc_bus_ctrl_pkg::*;
#(
    parameter int PHASE_CYC = PHASE_CYC_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic       wr_nrd,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       rtc_cs_n,
    output logic       rtc_as,
    output logic       rtc_rd_n,
    output logic       rtc_wr_n,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    input  logic [7:0] ad_in
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(PHASE_CYC - 1);

    state_e     state_q, state_d;
    logic       load, expired;
    logic       wr_q, done_q;
    logic [7:0] addr_q, wdata_q, rdata_q;

    rtc_phase_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (load),
        .load_val_i (RELOAD),
        .expired_o  (expired)
    );

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        busy     = 1'b1;
        rtc_cs_n = 1'b1;
        rtc_as   = 1'b0;
        rtc_rd_n = 1'b1;
        rtc_wr_n = 1'b1;
        ad_oe    = 1'b0;
        ad_out   = 8'h00;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (req) begin
                    state_d = ST_ADDR;
                    load    = 1'b1;
                end
            end
            ST_ADDR: begin
                rtc_cs_n = 1'b0;
                rtc_as   = 1'b1;
                ad_oe    = 1'b1;
                ad_out   = addr_q;
                if (expired) begin
                    state_d = ST_ADDR_HOLD;
                    load    = 1'b1;
                end
            end
            ST_ADDR_HOLD: begin
                rtc_cs_n = 1'b0;
                ad_oe    = 1'b1;
                ad_out   = addr_q;
                if (expired) begin
                    state_d = ST_ACCESS;
                    load    = 1'b1;
                end
            end
            ST_ACCESS: begin
                rtc_cs_n = 1'b0;
                // Bus is released on reads so the RTC can drive AD.
                if (wr_q) begin
                    rtc_wr_n = 1'b0;
                    ad_oe    = 1'b1;
                    ad_out   = wdata_q;
                end else begin
                    rtc_rd_n = 1'b0;
                end
                if (expired) begin
                    state_d = ST_RECOVER;
                    load    = 1'b1;
                end
            end
            ST_RECOVER: begin
                if (expired)
                    state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            wr_q    <= 1'b0;
            addr_q  <= 8'h00;
            wdata_q <= 8'h00;
            rdata_q <= 8'h00;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == ST_RECOVER) && expired;
            if (state_q == ST_IDLE && req) begin
                wr_q    <= wr_nrd;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            // Sample only on the last access cycle, when read data is settled.
            if (state_q == ST_ACCESS && !wr_q && expired)
                rdata_q <= ad_in;
        end
    end

    assign done  = done_q;
    assign rdata = rdata_q;

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// Directed bench for rtc_bus_ctrl: table-driven phase checks at PHASE_CYC=4
// and 1, plus back-to-back, ignored-request and mid-transaction reset cases.
module tb_rtc_bus_ctrl;

    typedef struct {
        int          lo;
        int          hi;
        logic [14:0] exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset, req, wr_nrd;
    logic [7:0] addr, wdata, ad_in;

    logic       busy4, done4, cs4, as4, rd4, wr4, oe4;
    logic [7:0] rdata4, ad4;
    logic       busy1, done1, cs1, as1, rd1, wr1, oe1;
    logic [7:0] rdata1, ad1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rtc_bus_ctrl #(.PHASE_CYC(4)) dut4 (
        .clk(clk), .reset(reset), .req(req), .wr_nrd(wr_nrd), .addr(addr), .wdata(wdata),
        .busy(busy4), .done(done4), .rdata(rdata4), .rtc_cs_n(cs4), .rtc_as(as4),
        .rtc_rd_n(rd4), .rtc_wr_n(wr4), .ad_out(ad4), .ad_oe(oe4), .ad_in(ad_in)
    );

    rtc_bus_ctrl #(.PHASE_CYC(1)) dut1 (
        .clk(clk), .reset(reset), .req(req), .wr_nrd(wr_nrd), .addr(addr), .wdata(wdata),
        .busy(busy1), .done(done1), .rdata(rdata1), .rtc_cs_n(cs1), .rtc_as(as1),
        .rtc_rd_n(rd1), .rtc_wr_n(wr1), .ad_out(ad1), .ad_oe(oe1), .ad_in(ad_in)
    );

    wire [14:0] out4 = {busy4, done4, cs4, as4, rd4, wr4, oe4, ad4};
    wire [14:0] out1 = {busy1, done1, cs1, as1, rd1, wr1, oe1, ad1};

    function automatic logic [14:0] mkv(input logic b, d, cs, as, rd, wr, oe,
                                        input logic [7:0] ad);
        return {b, d, cs, as, rd, wr, oe, ad};
    endfunction

    task automatic chk(input string nm, input int cyc, input logic [14:0] act,
                       input logic [14:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    // Strobe exclusivity and no drive while reading, checked every cycle.
    always @(negedge clk) begin
        if (!reset) begin
            total++;
            if ((!rd4 && !wr4) || (oe4 && !rd4) || (!rd1 && !wr1) || (oe1 && !rd1)) begin
                bad++;
                $display("FAIL strobe_excl t=%0t rd4=%b wr4=%b oe4=%b rd1=%b wr1=%b oe1=%b",
                         $time, rd4, wr4, oe4, rd1, wr1, oe1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic w, input logic [7:0] a, input logic [7:0] d);
        req = 1'b1; wr_nrd = w; addr = a; wdata = d;
    endtask

    // Runs cycles 1..ncyc of a transaction started in cycle 0 and checks the
    // selected instance against the phase table.
    task automatic run_table(input vec_t tbl[5], input int ncyc, input bit sel1,
                             input string nm);
        for (int c = 1; c <= ncyc; c++) begin
            tick();
            if (c == 1) req = 1'b0;
            ad_in = (c >= 9 && c <= 12) ? 8'h30 : 8'h99;
            for (int k = 0; k < 5; k++)
                if (c >= tbl[k].lo && c <= tbl[k].hi)
                    chk(nm, c, sel1 ? out1 : out4, tbl[k].exp);
        end
    endtask

    vec_t wr_tbl[5], rd_tbl[5], p1_tbl[5];
    logic [14:0] rst_v;
    int dones;

    initial begin
        rst_v = mkv(0, 0, 1, 0, 1, 1, 0, 8'h00);
        wr_tbl[0] = '{1, 4,   mkv(1, 0, 0, 1, 1, 1, 1, 8'h21)};
        wr_tbl[1] = '{5, 8,   mkv(1, 0, 0, 0, 1, 1, 1, 8'h21)};
        wr_tbl[2] = '{9, 12,  mkv(1, 0, 0, 0, 1, 0, 1, 8'h45)};
        wr_tbl[3] = '{13, 16, mkv(1, 0, 1, 0, 1, 1, 0, 8'h00)};
        wr_tbl[4] = '{17, 17, mkv(0, 1, 1, 0, 1, 1, 0, 8'h00)};
        rd_tbl[0] = '{1, 4,   mkv(1, 0, 0, 1, 1, 1, 1, 8'h22)};
        rd_tbl[1] = '{5, 8,   mkv(1, 0, 0, 0, 1, 1, 1, 8'h22)};
        rd_tbl[2] = '{9, 12,  mkv(1, 0, 0, 0, 0, 1, 0, 8'h00)};
        rd_tbl[3] = '{13, 16, mkv(1, 0, 1, 0, 1, 1, 0, 8'h00)};
        rd_tbl[4] = '{17, 17, mkv(0, 1, 1, 0, 1, 1, 0, 8'h00)};
        p1_tbl[0] = '{1, 1,   mkv(1, 0, 0, 1, 1, 1, 1, 8'hA5)};
        p1_tbl[1] = '{2, 2,   mkv(1, 0, 0, 0, 1, 1, 1, 8'hA5)};
        p1_tbl[2] = '{3, 3,   mkv(1, 0, 0, 0, 1, 0, 1, 8'h3C)};
        p1_tbl[3] = '{4, 4,   mkv(1, 0, 1, 0, 1, 1, 0, 8'h00)};
        p1_tbl[4] = '{5, 5,   mkv(0, 1, 1, 0, 1, 1, 0, 8'h00)};

        // Reset with a simultaneous request: request must be dropped.
        reset = 1'b1; ad_in = 8'h99;
        start(1'b1, 8'hEE, 8'h77);
        tick(); tick();
        chk("rst_out4", 0, out4, rst_v);
        chk("rst_out1", 0, out1, rst_v);
        chk("rst_rdata", 0, {7'd0, rdata4}, 15'h0);
        reset = 1'b0; req = 1'b0;
        tick();
        chk("rst_req_ignored", 0, out4, rst_v);

        start(1'b1, 8'h21, 8'h45);
        run_table(wr_tbl, 17, 1'b0, "wr4");
        chk("wr_rdata_kept", 17, {7'd0, rdata4}, 15'h0);

        start(1'b0, 8'h22, 8'h00);
        run_table(rd_tbl, 12, 1'b0, "rd4");
        chk("rd_rdata_pre", 12, {7'd0, rdata4}, 15'h0);
        tick();
        chk("rd_rdata_cap", 13, {7'd0, rdata4}, 15'h30);
        for (int c = 14; c <= 17; c++) tick();
        chk("rd_done", 17, {14'd0, done4}, 15'h1);
        chk("rd_rdata_done", 17, {7'd0, rdata4}, 15'h30);

        // Back-to-back: second request issued in the done cycle.
        start(1'b1, 8'h10, 8'h5E);
        dones = 0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (c == 1 || c == 18) req = 1'b0;
            ad_in = 8'(8'h40 + c - 17);
            if (done4) dones++;
            if (c == 17) begin
                chk("b2b_done1", c, {14'd0, done4}, 15'h1);
                start(1'b0, 8'h33, 8'h00);
            end
            if (c == 18)
                chk("b2b_addr2", c, {5'd0, as4, busy4, ad4}, {5'd0, 1'b1, 1'b1, 8'h33});
            if (c == 34) chk("b2b_done2", c, {14'd0, done4}, 15'h1);
        end
        chk("b2b_ndone", 40, 15'(dones), 15'd2);
        chk("b2b_rdata", 40, {7'd0, rdata4}, 15'h4C);

        // Requests while busy must not disturb the running read.
        start(1'b0, 8'h5A, 8'h00);
        ad_in = 8'h66; dones = 0;
        for (int c = 1; c <= 25; c++) begin
            tick();
            if (c == 1 || c == 4 || c == 11) req = 1'b0;
            if (c == 3 || c == 10) start(1'b1, 8'hEE, 8'h77);
            if (done4) dones++;
            if (c == 4 || c == 6) chk("ign_addr", c, {7'd0, ad4}, 15'h5A);
            if (c == 11) chk("ign_rdstrobe", c, {13'd0, rd4, wr4}, 15'b01);
            if (c == 17) chk("ign_done", c, {14'd0, done4}, 15'h1);
        end
        chk("ign_ndone", 25, 15'(dones), 15'd1);
        chk("ign_rdata", 25, {7'd0, rdata4}, 15'h66);

        // Reset in the middle of a read's access phase.
        start(1'b0, 8'h22, 8'h00);
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (c == 1) req = 1'b0;
            ad_in = 8'h30;
        end
        reset = 1'b1;
        tick();
        chk("mid_rst_out", 11, out4, rst_v);
        chk("mid_rst_rdata", 11, {7'd0, rdata4}, 15'h0);
        reset = 1'b0; dones = 0;
        for (int c = 12; c <= 31; c++) begin
            tick();
            if (done4) dones++;
        end
        chk("mid_rst_nodone", 31, 15'(dones), 15'd0);
        chk("mid_rst_rdata2", 31, {7'd0, rdata4}, 15'h0);

        // Single-cycle phases on the PHASE_CYC=1 instance (idle after reset).
        start(1'b1, 8'hA5, 8'h3C);
        run_table(p1_tbl, 5, 1'b1, "wr1");
        chk("p1_rdata", 5, {7'd0, rdata1}, 15'h0);
        for (int c = 0; c < 20; c++) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
